// File: rtl/muldiv_unit_pkg.sv
// ----------------------------------------------------------------------------
// muldiv_unit_pkg
//   Shared definitions for the execute-stage multiply/divide unit: the ALU
//   control codes it responds to, the FSM state encoding, and small helpers
//   that classify an ALU control code.
//
//   Contents:
//     EXE_MULT_OP / EXE_MULTU_OP / EXE_DIV_OP / EXE_DIVU_OP  8-bit ALU codes
//     md_state_e     MD_IDLE, MD_MUL, MD_DIV, MD_FIX
//     is_muldiv_op() 1 when the code is one of the four multiply/divide codes
//     is_div_op()    1 when the code is DIV or DIVU
// ----------------------------------------------------------------------------
package muldiv_unit_pkg;

    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_FIX  = 2'd3
    } md_state_e;

    function automatic logic is_muldiv_op(input logic [7:0] op);
        return (op == EXE_MULT_OP) || (op == EXE_MULTU_OP) ||
               (op == EXE_DIV_OP)  || (op == EXE_DIVU_OP);
    endfunction

    function automatic logic is_div_op(input logic [7:0] op);
        return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
    endfunction

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// ----------------------------------------------------------------------------
// muldiv_unit_div_iter
//   Restoring-division datapath working on unsigned magnitudes, one quotient
//   bit per step. The parent FSM loads it with start_i and advances it with
//   step_i; last_o flags the step that produces the final quotient bit.
//
//   Ports:
//     clk, resetn          clock, asynchronous active-low reset
//     start_i              load dividend/divisor, clear remainder and counter
//     step_i               perform one shift/subtract iteration
//     dividend_i           dividend magnitude (captured on start_i)
//     divisor_i            divisor magnitude (captured on start_i)
//     quo_o, rem_o         quotient / remainder magnitudes
//     last_o               high while the current step is the final one
// ----------------------------------------------------------------------------
module muldiv_unit_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quo_o,
    output logic [WIDTH-1:0] rem_o,
    output logic             last_o
);
    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;

    // The quotient register doubles as the dividend shift register: its MSB
    // feeds the partial remainder while quotient bits enter at the LSB.
    // Since the remainder is always below the divisor, the shifted value is
    // below twice the divisor, so bit WIDTH of the trial difference is a
    // pure borrow flag.
    always_comb begin
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        cnt_d     = cnt_q;
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        trial     = rem_shift - {1'b0, dvsr_q};
        if (start_i) begin
            rem_d  = '0;
            quo_d  = dividend_i;
            dvsr_d = divisor_i;
            cnt_d  = '0;
        end else if (step_i) begin
            if (!trial[WIDTH]) begin
                rem_d = trial[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = rem_shift[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvsr_q <= '0;
            cnt_q  <= '0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvsr_q <= dvsr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign quo_o  = quo_q;
    assign rem_o  = rem_q;
    assign last_o = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/muldiv_unit.sv
// ----------------------------------------------------------------------------
// muldiv_unit
//   Multi-cycle multiply/divide unit beside the ALU. Executes MULT, MULTU,
//   DIV and DIVU and returns the HI/LO pair, stalling the pipeline while an
//   operation is in flight. A flush (cancel_i) abandons the operation without
//   touching HI/LO.
//
//   Ports:
//     clk, resetn          clock, asynchronous active-low reset
//     start_i              request, only sampled while idle
//     op_i                 8-bit ALU control code
//     a_i, b_i             rs (multiplicand/dividend), rt (multiplier/divisor)
//     cancel_i             flush: abandon the in-flight operation
//     busy_o               an operation is in flight
//     stall_o              combinational pipeline stall
//     done_o               one-cycle pulse, HI/LO just updated
//     hi_o, lo_o           high product / remainder, low product / quotient
// ----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start_i,
    input  logic [7:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cancel_i,
    output logic             busy_o,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CNT_W = $clog2(MUL_LAT) + 1;

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] mul_cnt_q, mul_cnt_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             div_zero_q, div_zero_d;

    logic               accept;
    logic               op_signed;
    logic               op_is_div;
    logic [2*WIDTH-1:0] mul_a_ext, mul_b_ext, mul_prod, mul_tail;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   div_quo, div_rem, quo_fix, rem_fix;
    logic               div_start, div_step, div_last;

    assign op_is_div = is_div_op(op_i);
    assign op_signed = (op_i == EXE_MULT_OP) || (op_i == EXE_DIV_OP);
    assign accept    = (state_q == MD_IDLE) && start_i && is_muldiv_op(op_i) && !cancel_i;

    // Sign- or zero-extending to full width makes one unsigned multiplier
    // give the correct 2*WIDTH product for both MULT and MULTU.
    assign mul_a_ext = op_signed ? {{WIDTH{a_i[WIDTH-1]}}, a_i} : {{WIDTH{1'b0}}, a_i};
    assign mul_b_ext = op_signed ? {{WIDTH{b_i[WIDTH-1]}}, b_i} : {{WIDTH{1'b0}}, b_i};
    assign mul_prod  = mul_a_ext * mul_b_ext;

    // The HI/LO register is the last of the MUL_LAT delay stages, so only
    // MUL_LAT-1 stages sit in front of it. The pipe shifts every cycle; the
    // FSM commits its tail exactly MUL_LAT-1 cycles after the accept.
    generate
        if (MUL_LAT == 1) begin : g_mul_direct
            assign mul_tail = mul_prod;
        end else begin : g_mul_pipe
            logic [2*WIDTH-1:0] pipe_q [MUL_LAT-1];
            logic [2*WIDTH-1:0] pipe_d [MUL_LAT-1];

            always_comb begin
                pipe_d[0] = mul_prod;
                for (int i = 1; i < MUL_LAT - 1; i++) begin
                    pipe_d[i] = pipe_q[i-1];
                end
            end

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    for (int i = 0; i < MUL_LAT - 1; i++) begin
                        pipe_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < MUL_LAT - 1; i++) begin
                        pipe_q[i] <= pipe_d[i];
                    end
                end
            end

            assign mul_tail = pipe_q[MUL_LAT-2];
        end
    endgenerate

    // Divide runs on magnitudes; negating the most negative value yields the
    // same bit pattern, which is its correct unsigned magnitude.
    assign a_mag = (op_signed && a_i[WIDTH-1]) ? ({WIDTH{1'b0}} - a_i) : a_i;
    assign b_mag = (op_signed && b_i[WIDTH-1]) ? ({WIDTH{1'b0}} - b_i) : b_i;

    assign div_start = accept && op_is_div;
    assign div_step  = (state_q == MD_DIV) && !cancel_i;

    muldiv_unit_div_iter #(
        .WIDTH(WIDTH)
    ) u_div_iter (
        .clk       (clk),
        .resetn    (resetn),
        .start_i   (div_start),
        .step_i    (div_step),
        .dividend_i(a_mag),
        .divisor_i (b_mag),
        .quo_o     (div_quo),
        .rem_o     (div_rem),
        .last_o    (div_last)
    );

    // Most-negative / -1 needs no special case: the magnitude quotient is
    // 2^(WIDTH-1), whose negation is the same pattern, and the remainder is 0.
    assign quo_fix = q_neg_q ? ({WIDTH{1'b0}} - div_quo) : div_quo;
    assign rem_fix = r_neg_q ? ({WIDTH{1'b0}} - div_rem) : div_rem;

    // HI/LO and done are only written on the commit edge that leaves the
    // unit idle, so a cancel on that edge leaves the old result untouched.
    always_comb begin
        state_d    = state_q;
        mul_cnt_d  = mul_cnt_q;
        done_d     = 1'b0;
        hi_d       = hi_q;
        lo_d       = lo_q;
        dividend_d = dividend_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        div_zero_d = div_zero_q;
        case (state_q)
            MD_IDLE: begin
                if (accept) begin
                    if (op_is_div) begin
                        state_d    = MD_DIV;
                        dividend_d = a_i;
                        q_neg_d    = op_signed && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                        r_neg_d    = op_signed && a_i[WIDTH-1];
                        div_zero_d = (b_i == '0);
                    end else if (MUL_LAT == 1) begin
                        hi_d   = mul_tail[2*WIDTH-1:WIDTH];
                        lo_d   = mul_tail[WIDTH-1:0];
                        done_d = 1'b1;
                    end else begin
                        state_d   = MD_MUL;
                        mul_cnt_d = CNT_W'(1);
                    end
                end
            end
            MD_MUL: begin
                if (cancel_i) begin
                    state_d   = MD_IDLE;
                    mul_cnt_d = '0;
                end else if (mul_cnt_q == CNT_W'(MUL_LAT - 1)) begin
                    state_d   = MD_IDLE;
                    mul_cnt_d = '0;
                    hi_d      = mul_tail[2*WIDTH-1:WIDTH];
                    lo_d      = mul_tail[WIDTH-1:0];
                    done_d    = 1'b1;
                end else begin
                    mul_cnt_d = mul_cnt_q + 1'b1;
                end
            end
            MD_DIV: begin
                if (cancel_i) begin
                    state_d = MD_IDLE;
                end else if (div_last) begin
                    state_d = MD_FIX;
                end
            end
            MD_FIX: begin
                state_d = MD_IDLE;
                if (!cancel_i) begin
                    done_d = 1'b1;
                    if (div_zero_q) begin
                        lo_d = '1;
                        hi_d = dividend_q;
                    end else begin
                        lo_d = quo_fix;
                        hi_d = rem_fix;
                    end
                end
            end
            default: begin
                state_d = MD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= MD_IDLE;
            mul_cnt_q  <= '0;
            done_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            dividend_q <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mul_cnt_q  <= mul_cnt_d;
            done_q     <= done_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            dividend_q <= dividend_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy_o  = (state_q != MD_IDLE);
    assign stall_o = busy_o | accept;
    assign done_o  = done_q;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_muldiv_unit
//   Directed bench for muldiv_unit at WIDTH=32, MUL_LAT=2. Each accepted
//   operation pushes its expected HI/LO and latency onto a scoreboard queue,
//   which is popped when done_o is seen. Inputs change 1 ns after the rising
//   edge and outputs are sampled there too.
// ----------------------------------------------------------------------------
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int WIDTH   = 32;
    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = WIDTH + 2;
    localparam logic [7:0] ADD_OP = 8'b0010_0000;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    logic        clk      = 1'b0;
    logic        resetn   = 1'b1;
    logic        start_i  = 1'b0;
    logic [7:0]  op_i     = 8'h00;
    logic [31:0] a_i      = '0;
    logic [31:0] b_i      = '0;
    logic        cancel_i = 1'b0;
    logic        busy_o, stall_o, done_o;
    logic [31:0] hi_o, lo_o;

    exp_t        sb_q[$];
    int          errors  = 0;
    int          checks  = 0;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    always #5 clk = ~clk;

    muldiv_unit #(
        .WIDTH  (WIDTH),
        .MUL_LAT(MUL_LAT)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .start_i (start_i),
        .op_i    (op_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .cancel_i(cancel_i),
        .busy_o  (busy_o),
        .stall_o (stall_o),
        .done_o  (done_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: 64-bit arithmetic with explicit divide-by-zero rule.
    function automatic logic [63:0] model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, sq, sr;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (op)
            EXE_MULT_OP:  p = 64'(sa * sb);
            EXE_MULTU_OP: p = {32'b0, a} * {32'b0, b};
            EXE_DIVU_OP:  p = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            EXE_DIV_OP: begin
                if (b == 0) begin
                    p = {a, 32'hFFFF_FFFF};
                end else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    p  = {sr[31:0], sq[31:0]};
                end
            end
            default: p = '0;
        endcase
        return p;
    endfunction

    // Drives a one-cycle request; the request is expected to be accepted.
    task automatic applyStimulus(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        start_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        #1;
        checkOutput("stall in accept cycle", stall_o, 1);
        tick();
        start_i = 1'b0;
    endtask

    task automatic pushExpected(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        r = model(op, a, b);
        sb_q.push_back('{r[63:32], r[31:0], is_div_op(op) ? DIV_LAT : MUL_LAT});
    endtask

    // Waits (bounded) for done_o starting at relative cycle first_cycle,
    // checking stall/busy along the way, then pops and compares the result.
    task automatic awaitResult(input string tag, input int first_cycle);
        int   n;
        bit   seen;
        exp_t e;
        n    = first_cycle;
        seen = 1'b0;
        while (n <= 60) begin
            if (done_o === 1'b1) begin
                seen = 1'b1;
                break;
            end
            checkOutput({tag, " stall/busy while running"}, {62'b0, stall_o, busy_o}, 64'd3);
            tick();
            n++;
        end
        checkOutput({tag, " done seen"}, 64'(seen), 64'd1);
        checkOutput({tag, " scoreboard entry"}, 64'(sb_q.size()), 64'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (seen) begin
                checkOutput({tag, " latency"}, 64'(n), 64'(e.lat));
                checkOutput({tag, " hi"}, hi_o, e.hi);
                checkOutput({tag, " lo"}, lo_o, e.lo);
                checkOutput({tag, " busy in done cycle"}, busy_o, 0);
                checkOutput({tag, " stall in done cycle"}, stall_o, 0);
                last_hi = e.hi;
                last_lo = e.lo;
            end
        end
    endtask

    task automatic checkHeld(input string tag);
        tick();
        checkOutput({tag, " done pulse ends"}, done_o, 0);
        checkOutput({tag, " hi held"}, hi_o, last_hi);
        checkOutput({tag, " lo held"}, lo_o, last_lo);
    endtask

    task automatic checkNoDone(input string tag, input int cycles);
        bit saw;
        saw = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            saw |= done_o;
            tick();
        end
        checkOutput({tag, " no done"}, 64'(saw), 64'd0);
        checkOutput({tag, " hi retained"}, hi_o, last_hi);
        checkOutput({tag, " lo retained"}, lo_o, last_lo);
    endtask

    initial begin
        logic [7:0]  ops [4];
        logic [7:0]  rop;
        logic [31:0] ra, rb;
        ops = '{EXE_MULT_OP, EXE_MULTU_OP, EXE_DIV_OP, EXE_DIVU_OP};

        // Reset state
        #1 resetn = 1'b0;
        tick();
        tick();
        checkOutput("reset busy", busy_o, 0);
        checkOutput("reset done", done_o, 0);
        checkOutput("reset stall", stall_o, 0);
        checkOutput("reset hi", hi_o, 0);
        checkOutput("reset lo", lo_o, 0);
        resetn = 1'b1;
        tick();

        // Signed and unsigned multiply
        pushExpected(EXE_MULT_OP, 32'hFFFF_FFFE, 32'd3);
        applyStimulus(EXE_MULT_OP, 32'hFFFF_FFFE, 32'd3);
        awaitResult("MULT -2*3", 1);
        checkOutput("MULT -2*3 hi const", hi_o, 32'hFFFF_FFFF);
        checkOutput("MULT -2*3 lo const", lo_o, 32'hFFFF_FFFA);
        checkHeld("MULT -2*3");

        pushExpected(EXE_MULTU_OP, 32'hFFFF_FFFE, 32'd3);
        applyStimulus(EXE_MULTU_OP, 32'hFFFF_FFFE, 32'd3);
        awaitResult("MULTU", 1);
        checkOutput("MULTU hi const", hi_o, 32'h0000_0002);
        checkOutput("MULTU lo const", lo_o, 32'hFFFF_FFFA);

        // Divide sign correction
        tick();
        pushExpected(EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2);
        applyStimulus(EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2);
        awaitResult("DIV -7/2", 1);
        checkOutput("DIV -7/2 lo const", lo_o, 32'hFFFF_FFFD);
        checkOutput("DIV -7/2 hi const", hi_o, 32'hFFFF_FFFF);
        checkHeld("DIV -7/2");

        pushExpected(EXE_DIVU_OP, 32'd7, 32'd2);
        applyStimulus(EXE_DIVU_OP, 32'd7, 32'd2);
        awaitResult("DIVU 7/2", 1);

        // Divide by zero (unsigned and signed) and signed overflow
        tick();
        pushExpected(EXE_DIVU_OP, 32'h1234, 32'd0);
        applyStimulus(EXE_DIVU_OP, 32'h1234, 32'd0);
        awaitResult("DIVU by zero", 1);
        checkOutput("DIVU by zero lo const", lo_o, 32'hFFFF_FFFF);
        checkOutput("DIVU by zero hi const", hi_o, 32'h0000_1234);

        tick();
        pushExpected(EXE_DIV_OP, 32'hFFFF_FFF9, 32'd0);
        applyStimulus(EXE_DIV_OP, 32'hFFFF_FFF9, 32'd0);
        awaitResult("DIV by zero", 1);

        tick();
        pushExpected(EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF);
        applyStimulus(EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF);
        awaitResult("DIV overflow", 1);
        checkOutput("DIV overflow lo const", lo_o, 32'h8000_0000);
        checkOutput("DIV overflow hi const", hi_o, 32'h0000_0000);

        // Cancel during DIV at cycle 10
        tick();
        applyStimulus(EXE_DIV_OP, 32'd100, 32'd7);
        for (int i = 1; i < 10; i++) tick();
        cancel_i = 1'b1;
        tick();
        cancel_i = 1'b0;
        checkOutput("cancel busy at cycle 11", busy_o, 0);
        checkNoDone("cancelled DIV", 40);

        // Cancel together with start blocks the accept
        start_i  = 1'b1;
        op_i     = EXE_DIV_OP;
        a_i      = 32'd50;
        b_i      = 32'd5;
        cancel_i = 1'b1;
        #1;
        checkOutput("cancel+start stall", stall_o, 0);
        tick();
        start_i  = 1'b0;
        cancel_i = 1'b0;
        checkOutput("cancel+start busy", busy_o, 0);
        checkNoDone("cancel+start", 40);

        // start_i re-asserted while a DIVU is busy is ignored
        pushExpected(EXE_DIVU_OP, 32'd7, 32'd2);
        applyStimulus(EXE_DIVU_OP, 32'd7, 32'd2);
        tick();
        tick();
        tick();
        start_i = 1'b1;
        op_i    = EXE_MULTU_OP;
        a_i     = 32'd9;
        b_i     = 32'd9;
        tick();
        start_i = 1'b0;
        awaitResult("DIVU with ignored start", 5);

        // Back-to-back MULTs: second accepted in the first one's done cycle
        tick();
        pushExpected(EXE_MULT_OP, 32'd3, 32'd4);
        applyStimulus(EXE_MULT_OP, 32'd3, 32'd4);
        awaitResult("MULT first", 1);
        pushExpected(EXE_MULT_OP, 32'hFFFF_FFFF, 32'd5);
        applyStimulus(EXE_MULT_OP, 32'hFFFF_FFFF, 32'd5);
        awaitResult("MULT back-to-back", 1);
        checkHeld("MULT back-to-back");

        // Non-muldiv op is ignored
        start_i = 1'b1;
        op_i    = ADD_OP;
        a_i     = 32'd1;
        b_i     = 32'd2;
        #1;
        checkOutput("ADD stall", stall_o, 0);
        tick();
        start_i = 1'b0;
        checkOutput("ADD busy", busy_o, 0);
        checkNoDone("ADD op", 10);

        // Asynchronous reset at cycle 5 of a DIV
        applyStimulus(EXE_DIV_OP, 32'd1000, 32'd3);
        for (int i = 1; i < 5; i++) tick();
        #2 resetn = 1'b0;
        #1;
        checkOutput("mid reset busy", busy_o, 0);
        checkOutput("mid reset done", done_o, 0);
        checkOutput("mid reset stall", stall_o, 0);
        checkOutput("mid reset hi", hi_o, 0);
        checkOutput("mid reset lo", lo_o, 0);
        tick();
        tick();
        resetn = 1'b1;
        tick();
        pushExpected(EXE_MULTU_OP, 32'd5, 32'd6);
        applyStimulus(EXE_MULTU_OP, 32'd5, 32'd6);
        awaitResult("MULTU after reset", 1);
        checkOutput("MULTU after reset lo const", lo_o, 32'd30);
        checkOutput("MULTU after reset hi const", hi_o, 32'd0);

        // A handful of mixed operations against the model
        for (int k = 0; k < 6; k++) begin
            tick();
            rop = ops[$urandom_range(0, 3)];
            ra  = $urandom;
            rb  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            if ($urandom_range(0, 1) == 1) rb = -rb;
            pushExpected(rop, ra, rb);
            applyStimulus(rop, ra, rb);
            awaitResult("mixed op", 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
